split_bus_arbiter: RTL and testbench

- Two-master/multi-slave serial bus arbiter with split-transaction support.
- Grants the shared bus to master 1 or master 2 and captures the bit-serial slave address from the owner's tx line.
- Hands the address to the address decoder, then tracks the slave handshake.
- Parks a master when the addressed slave issues a split, and lets the other master use the bus until the slave releases it.

---
 rtl/split_bus_arbiter.sv | 255 +++++++++++++++++++++++++
 tb/tb_split_bus_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/split_bus_arbiter.sv
// split_bus_arbiter
//   Two-master serial bus arbiter with split-transaction support. Grants the
//   shared bus to one master, shifts in the bit-serial slave address from the
//   owner's tx line (start bit 0, then ADDR_W bits MSB first), then follows
//   the slave handshake. A slave split parks the owner with its address
//   saved. A later split_release resumes that master directly in WAIT_SLV.
//
// Ports
//   clk            bus clock, rising edge
//   rstn           synchronous reset, active high (1 resets on the next edge)
//   m1_req/m2_req  level bus requests
//   m1_tx/m2_tx    master serial lines, idle high
//   slv_ready      slave accepted the transaction
//   slv_split      slave defers the transaction (split)
//   slv_responded  slave finished the transaction
//   split_release  bit i: slave ready to resume master i+1
//   m1_gnt/m2_gnt  bus grants, mutually exclusive
//   m1_split/m2_split  master parked in split
//   addr           captured or restored slave address
//   addr_rdy       one-cycle strobe, addr valid
//   owner          0 = m1, 1 = m2, valid while a grant is high
//   timeout        one-cycle strobe on forced release
module split_bus_arbiter #(
  parameter int unsigned ADDR_W  = 2,
  parameter int unsigned RR_EN   = 1,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              m1_req,
  input  logic              m2_req,
  input  logic              m1_tx,
  input  logic              m2_tx,
  input  logic              slv_ready,
  input  logic              slv_split,
  input  logic              slv_responded,
  input  logic [1:0]        split_release,
  output logic              m1_gnt,
  output logic              m2_gnt,
  output logic              m1_split,
  output logic              m2_split,
  output logic [ADDR_W-1:0] addr,
  output logic              addr_rdy,
  output logic              owner,
  output logic              timeout
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned BIT_W = (ADDR_W > 1) ? $clog2(ADDR_W) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(ADDR_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    ADDR,
    WAIT_SLV,
    DATA
  } state_t;

  state_t            state, state_nxt;
  logic [BIT_W-1:0]  bitcnt, bitcnt_nxt;
  logic [ADDR_W-1:0] shift, shift_nxt;
  logic [CNT_W-1:0]  tmo_cnt, tmo_nxt;
  logic              last_owner, last_nxt;
  logic [ADDR_W-1:0] sav1, sav1_nxt;
  logic [ADDR_W-1:0] sav2, sav2_nxt;
  logic              gnt1_nxt, gnt2_nxt;
  logic              split1_nxt, split2_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic              addr_rdy_nxt;
  logic              owner_nxt;
  logic              timeout_nxt;

  logic              own_tx;
  logic              own_req;
  logic              elig1, elig2;
  logic              win;
  logic              tmo_hit;
  logic              force_rel;

  // Next-state and registered-output computation
  always_comb begin
    state_nxt    = state;
    bitcnt_nxt   = bitcnt;
    shift_nxt    = shift;
    tmo_nxt      = tmo_cnt;
    last_nxt     = last_owner;
    sav1_nxt     = sav1;
    sav2_nxt     = sav2;
    gnt1_nxt     = m1_gnt;
    gnt2_nxt     = m2_gnt;
    split1_nxt   = m1_split;
    split2_nxt   = m2_split;
    addr_nxt     = addr;
    addr_rdy_nxt = 1'b0;
    owner_nxt    = owner;
    timeout_nxt  = 1'b0;
    win          = 1'b0;
    force_rel    = 1'b0;

    own_tx  = owner ? m2_tx : m1_tx;
    own_req = owner ? m2_req : m1_req;
    elig1   = m1_req & ~m1_split;
    elig2   = m2_req & ~m2_split;
    tmo_hit = (tmo_cnt == TMO_LAST);

    case (state)
      IDLE: begin
        // Resumed splits beat new requests; m1 resumes first on a double release
        if (split_release[0] && m1_split) begin
          split1_nxt   = 1'b0;
          owner_nxt    = 1'b0;
          gnt1_nxt     = 1'b1;
          addr_nxt     = sav1;
          addr_rdy_nxt = 1'b1;
          state_nxt    = WAIT_SLV;
        end else if (split_release[1] && m2_split) begin
          split2_nxt   = 1'b0;
          owner_nxt    = 1'b1;
          gnt2_nxt     = 1'b1;
          addr_nxt     = sav2;
          addr_rdy_nxt = 1'b1;
          state_nxt    = WAIT_SLV;
        end else if (elig1 || elig2) begin
          // On a tie round-robin picks the master that did not own the bus last
          if (elig1 && elig2) begin
            win = (RR_EN != 0) ? ~last_owner : 1'b0;
          end else begin
            win = elig2;
          end
          owner_nxt = win;
          gnt1_nxt  = ~win;
          gnt2_nxt  = win;
          state_nxt = GRANT;
        end
      end

      GRANT: begin
        if (!own_req) begin
          gnt1_nxt  = 1'b0;
          gnt2_nxt  = 1'b0;
          state_nxt = IDLE;
        end else if (!own_tx) begin
          bitcnt_nxt = '0;
          state_nxt  = ADDR;
        end else if (tmo_hit) begin
          force_rel = 1'b1;
        end
      end

      ADDR: begin
        // Shift MSB first; the last bit goes straight into addr
        shift_nxt = ADDR_W'({shift, own_tx});
        if (bitcnt == BIT_LAST) begin
          addr_nxt     = shift_nxt;
          addr_rdy_nxt = 1'b1;
          state_nxt    = WAIT_SLV;
        end else begin
          bitcnt_nxt = BIT_W'(bitcnt + 1'b1);
        end
      end

      WAIT_SLV: begin
        if (slv_ready) begin
          state_nxt = DATA;
        end else if (slv_split) begin
          if (owner) begin
            split2_nxt = 1'b1;
            sav2_nxt   = addr;
          end else begin
            split1_nxt = 1'b1;
            sav1_nxt   = addr;
          end
          gnt1_nxt  = 1'b0;
          gnt2_nxt  = 1'b0;
          state_nxt = IDLE;
        end else if (tmo_hit) begin
          force_rel = 1'b1;
        end
      end

      DATA: begin
        if (slv_responded) begin
          gnt1_nxt  = 1'b0;
          gnt2_nxt  = 1'b0;
          last_nxt  = owner;
          state_nxt = IDLE;
        end else if (tmo_hit) begin
          force_rel = 1'b1;
        end
      end

      default: begin
        gnt1_nxt  = 1'b0;
        gnt2_nxt  = 1'b0;
        state_nxt = IDLE;
      end
    endcase

    // Forced release leaves split flags alone
    if (force_rel) begin
      timeout_nxt = 1'b1;
      gnt1_nxt    = 1'b0;
      gnt2_nxt    = 1'b0;
      last_nxt    = owner;
      state_nxt   = IDLE;
    end

    // Watchdog restarts on every state change, counts only in bounded states
    if (state_nxt != state) begin
      tmo_nxt = '0;
    end else if (state == GRANT || state == WAIT_SLV || state == DATA) begin
      tmo_nxt = CNT_W'(tmo_cnt + 1'b1);
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rstn) begin
      state      <= IDLE;
      bitcnt     <= '0;
      shift      <= '0;
      tmo_cnt    <= '0;
      last_owner <= 1'b1;
      sav1       <= '0;
      sav2       <= '0;
      m1_gnt     <= 1'b0;
      m2_gnt     <= 1'b0;
      m1_split   <= 1'b0;
      m2_split   <= 1'b0;
      addr       <= '0;
      addr_rdy   <= 1'b0;
      owner      <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state      <= state_nxt;
      bitcnt     <= bitcnt_nxt;
      shift      <= shift_nxt;
      tmo_cnt    <= tmo_nxt;
      last_owner <= last_nxt;
      sav1       <= sav1_nxt;
      sav2       <= sav2_nxt;
      m1_gnt     <= gnt1_nxt;
      m2_gnt     <= gnt2_nxt;
      m1_split   <= split1_nxt;
      m2_split   <= split2_nxt;
      addr       <= addr_nxt;
      addr_rdy   <= addr_rdy_nxt;
      owner      <= owner_nxt;
      timeout    <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_split_bus_arbiter.sv
// Bench for split_bus_arbiter. Instance a uses round-robin, instance b fixed
// priority; both share all inputs. Expected address/owner pairs are queued
// when stimulus is driven and compared when addr_rdy is seen.
module tb_split_bus_arbiter;

  localparam int unsigned ADDR_W = 2;
  localparam int unsigned TMO    = 64;

  typedef struct packed {
    logic              own;
    logic [ADDR_W-1:0] a;
  } exp_t;

  logic              clk = 1'b0;
  logic              rstn;
  logic              m1_req, m2_req, m1_tx, m2_tx;
  logic              slv_ready, slv_split, slv_responded;
  logic [1:0]        split_release;

  logic              a_m1_gnt, a_m2_gnt, a_m1_split, a_m2_split;
  logic [ADDR_W-1:0] a_addr;
  logic              a_addr_rdy, a_owner, a_timeout;
  logic              b_m1_gnt, b_m2_gnt, b_m1_split, b_m2_split;
  logic [ADDR_W-1:0] b_addr;
  logic              b_addr_rdy, b_owner, b_timeout;

  int   total = 0;
  int   bad   = 0;
  bit   mon_en = 1'b0;
  bit   b_mon  = 1'b0;
  exp_t qa[$];
  exp_t qb[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  split_bus_arbiter #(.ADDR_W(ADDR_W), .RR_EN(1), .TIMEOUT(TMO)) dut_a (
    .clk(clk), .rstn(rstn), .m1_req(m1_req), .m2_req(m2_req),
    .m1_tx(m1_tx), .m2_tx(m2_tx), .slv_ready(slv_ready), .slv_split(slv_split),
    .slv_responded(slv_responded), .split_release(split_release),
    .m1_gnt(a_m1_gnt), .m2_gnt(a_m2_gnt), .m1_split(a_m1_split), .m2_split(a_m2_split),
    .addr(a_addr), .addr_rdy(a_addr_rdy), .owner(a_owner), .timeout(a_timeout)
  );

  split_bus_arbiter #(.ADDR_W(ADDR_W), .RR_EN(0), .TIMEOUT(TMO)) dut_b (
    .clk(clk), .rstn(rstn), .m1_req(m1_req), .m2_req(m2_req),
    .m1_tx(m1_tx), .m2_tx(m2_tx), .slv_ready(slv_ready), .slv_split(slv_split),
    .slv_responded(slv_responded), .split_release(split_release),
    .m1_gnt(b_m1_gnt), .m2_gnt(b_m2_gnt), .m1_split(b_m1_split), .m2_split(b_m2_split),
    .addr(b_addr), .addr_rdy(b_addr_rdy), .owner(b_owner), .timeout(b_timeout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_a(input logic own, input logic [ADDR_W-1:0] a);
    exp_t e;
    e.own = own;
    e.a   = a;
    qa.push_back(e);
  endtask

  task automatic push_b(input logic own, input logic [ADDR_W-1:0] a);
    exp_t e;
    e.own = own;
    e.a   = a;
    qb.push_back(e);
  endtask

  // Scoreboard and grant-exclusivity monitor, sampled away from the rising edge
  always @(negedge clk) begin
    if (mon_en) begin
      check("gnt_excl_a", 32'(a_m1_gnt & a_m2_gnt), 0);
      check("gnt_excl_b", 32'(b_m1_gnt & b_m2_gnt), 0);
      if (a_addr_rdy) begin
        if (qa.size() == 0) begin
          check("sb_a_unexpected", 32'(a_addr_rdy), 0);
        end else begin
          mon_e = qa.pop_front();
          check("sb_a_addr", 32'(a_addr), 32'(mon_e.a));
          check("sb_a_owner", 32'(a_owner), 32'(mon_e.own));
          check("sb_a_gnt", 32'(mon_e.own ? a_m2_gnt : a_m1_gnt), 1);
        end
      end
      if (b_mon && b_addr_rdy) begin
        if (qb.size() == 0) begin
          check("sb_b_unexpected", 32'(b_addr_rdy), 0);
        end else begin
          mon_e = qb.pop_front();
          check("sb_b_addr", 32'(b_addr), 32'(mon_e.a));
          check("sb_b_owner", 32'(b_owner), 32'(mon_e.own));
        end
      end
    end
  end

  task automatic do_reset();
    rstn = 1'b1;
    m1_req = 1'b0; m2_req = 1'b0; m1_tx = 1'b1; m2_tx = 1'b1;
    slv_ready = 1'b0; slv_split = 1'b0; slv_responded = 1'b0;
    split_release = 2'b00;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b0;
  endtask

  task automatic wait_gnt(output int cyc);
    cyc = 0;
    while (!(a_m1_gnt || a_m2_gnt) && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    if (!(a_m1_gnt || a_m2_gnt)) check("gnt_wait_expired", 0, 1);
  endtask

  // Start bit then ADDR_W bits MSB first on both lines; ends on the addr_rdy cycle
  task automatic run_addr(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] v;
    v = a;
    m1_tx = 1'b0; m2_tx = 1'b0;
    @(negedge clk);
    for (int i = int'(ADDR_W) - 1; i >= 0; i--) begin
      m1_tx = v[i]; m2_tx = v[i];
      @(negedge clk);
    end
    m1_tx = 1'b1; m2_tx = 1'b1;
    check("addr_rdy_lat", 32'(a_addr_rdy), 1);
  endtask

  task automatic finish_xact();
    slv_ready = 1'b1;
    @(negedge clk);
    slv_ready = 1'b0; slv_responded = 1'b1;
    @(negedge clk);
    slv_responded = 1'b0;
    check("gnt_drop_a", 32'(a_m1_gnt | a_m2_gnt), 0);
    if (b_mon) check("gnt_drop_b", 32'(b_m1_gnt | b_m2_gnt), 0);
  endtask

  initial begin
    int cyc;
    int n;
    logic [ADDR_W-1:0] rr_addr;

    // Reset state
    do_reset();
    check("rst_outs", 32'({a_m1_gnt, a_m2_gnt, a_m1_split, a_m2_split,
                           a_addr, a_addr_rdy, a_owner, a_timeout}), 0);
    mon_en = 1'b1;

    // Single master, address 2'b10
    m1_req = 1'b1;
    wait_gnt(cyc);
    check("t1_gnt_lat", 32'(cyc), 1);
    check("t1_owner", 32'(a_owner), 0);
    push_a(1'b0, 2'b10);
    run_addr(2'b10);
    finish_xact();
    m1_req = 1'b0;
    @(negedge clk);

    // Simultaneous requests: a alternates, b keeps m1
    do_reset();
    b_mon = 1'b1;
    m1_req = 1'b1; m2_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      rr_addr = ADDR_W'(k);
      wait_gnt(cyc);
      check("rr_owner_a", 32'(a_owner), 32'(k % 2));
      check("rr_gnt_b_m1", 32'(b_m1_gnt), 1);
      push_a(1'((k % 2) != 0), rr_addr);
      push_b(1'b0, rr_addr);
      run_addr(rr_addr);
      finish_xact();
    end
    m1_req = 1'b0; m2_req = 1'b0;
    @(negedge clk);
    b_mon = 1'b0;

    // Split of m1 on slave 2'b01; m2 runs; release resumes m1
    do_reset();
    m1_req = 1'b1;
    wait_gnt(cyc);
    m2_req = 1'b1;
    push_a(1'b0, 2'b01);
    run_addr(2'b01);
    slv_split = 1'b1;
    @(negedge clk);
    slv_split = 1'b0;
    check("sp_m1_split", 32'(a_m1_split), 1);
    check("sp_m1_gnt", 32'(a_m1_gnt), 0);
    wait_gnt(cyc);
    check("sp_m2_next", 32'({a_m2_gnt, cyc[3:0]}), 32'({1'b1, 4'd1}));
    push_a(1'b1, 2'b11);
    run_addr(2'b11);
    finish_xact();
    m2_req = 1'b0;
    split_release = 2'b01;
    push_a(1'b0, 2'b01);
    @(negedge clk);
    split_release = 2'b00;
    check("rel_m1_gnt", 32'(a_m1_gnt), 1);
    check("rel_m1_split", 32'(a_m1_split), 0);
    finish_xact();
    m1_req = 1'b0;
    @(negedge clk);

    // Release of m2 beats a new m1 request in the same IDLE cycle
    do_reset();
    m2_req = 1'b1;
    wait_gnt(cyc);
    check("rv_owner_m2", 32'(a_owner), 1);
    push_a(1'b1, 2'b10);
    run_addr(2'b10);
    slv_split = 1'b1;
    @(negedge clk);
    slv_split = 1'b0;
    check("rv_m2_split", 32'(a_m2_split), 1);
    m1_req = 1'b1; split_release = 2'b10;
    push_a(1'b1, 2'b10);
    @(negedge clk);
    split_release = 2'b00;
    check("rv_m2_resume", 32'({a_m2_gnt, a_m1_gnt}), 32'(2'b10));
    check("rv_m2_split_clr", 32'(a_m2_split), 0);
    finish_xact();
    m2_req = 1'b0;
    wait_gnt(cyc);
    check("rv_m1_after", 32'({a_m1_gnt, a_owner}), 32'(2'b10));
    push_a(1'b0, 2'b00);
    run_addr(2'b00);
    finish_xact();
    m1_req = 1'b0;
    @(negedge clk);

    // Owner drops its request while in GRANT
    m1_req = 1'b1;
    wait_gnt(cyc);
    m1_req = 1'b0;
    @(negedge clk);
    check("gr_drop", 32'(a_m1_gnt), 0);

    // Slave never answers: forced release 64 cycles into WAIT_SLV
    do_reset();
    m1_req = 1'b1;
    wait_gnt(cyc);
    push_a(1'b0, 2'b11);
    run_addr(2'b11);
    n = 0;
    while (!a_timeout && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("tmo_cycles", 32'(n), TMO);
    check("tmo_gnt", 32'(a_m1_gnt), 0);
    check("tmo_split", 32'(a_m1_split), 0);
    m1_req = 1'b0;
    @(negedge clk);
    check("tmo_pulse", 32'(a_timeout), 0);
    check("tmo_idle", 32'(a_m1_gnt | a_m2_gnt), 0);

    // Reset during DATA with m2 parked
    do_reset();
    m2_req = 1'b1;
    wait_gnt(cyc);
    push_a(1'b1, 2'b01);
    run_addr(2'b01);
    slv_split = 1'b1;
    @(negedge clk);
    slv_split = 1'b0;
    m1_req = 1'b1;
    wait_gnt(cyc);
    push_a(1'b0, 2'b10);
    run_addr(2'b10);
    slv_ready = 1'b1;
    @(negedge clk);
    slv_ready = 1'b0;
    check("rd_pre_split", 32'(a_m2_split), 1);
    rstn = 1'b1;
    @(negedge clk);
    rstn = 1'b0;
    check("rd_outs", 32'({a_m1_gnt, a_m2_gnt, a_m1_split, a_m2_split,
                          a_addr, a_addr_rdy, a_owner, a_timeout}), 0);
    wait_gnt(cyc);
    check("rd_m1_wins", 32'({a_m1_gnt, a_m2_gnt}), 32'(2'b10));
    m1_req = 1'b0; m2_req = 1'b0;
    @(negedge clk);

    check("sb_a_left", 32'(qa.size()), 0);
    check("sb_b_left", 32'(qb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
